// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter that sequences two requesters onto the spi_ram command port.
// Optional read watchdog enabled by defining RAM_ARB_TIMEOUT_EN (adds err_timeout).
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_wr,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [7:0]           req0_wdata,
  output logic                 rsp0_valid,
  output logic [7:0]           rsp0_rdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_wr,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [7:0]           req1_wdata,
  output logic                 rsp1_valid,
  output logic [7:0]           rsp1_rdata,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic                 ram_tx_valid,
  input  logic [7:0]           ram_dout,
  output logic                 busy
`ifdef RAM_ARB_TIMEOUT_EN
  ,
  output logic                 err_timeout
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_ADDR,
    SEND_WDATA,
    SEND_RD,
    WAIT_RD
  } state_t;

  state_t                 state_q, state_d;
  logic                   rr_last_q, rr_last_d;
  logic                   wr_q, wr_d;
  logic                   id_q, id_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   rsp0_valid_q, rsp0_valid_d;
  logic [7:0]             rsp0_rdata_q, rsp0_rdata_d;
  logic                   rsp1_valid_q, rsp1_valid_d;
  logic [7:0]             rsp1_rdata_q, rsp1_rdata_d;
  logic                   rsp_fire;
  logic [7:0]             rsp_data;
  logic                   grant0, grant1;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
`else
  // TIMEOUT only configures the optional watchdog.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // On contention the requester that was not served last wins.
  assign grant0 = req0_valid && (!req1_valid || rr_last_q);
  assign grant1 = req1_valid && (!req0_valid || !rr_last_q);

  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;
  assign busy       = (state_q != IDLE);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_rdata = rsp1_rdata_q;
`ifdef RAM_ARB_TIMEOUT_EN
  assign err_timeout = err_q;
`endif

  always_comb begin
    ram_rx_valid = 1'b0;
    ram_din      = '0;
    case (state_q)
      SEND_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {(wr_q ? 2'b00 : 2'b10), addr_q};
      end
      SEND_WDATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = {2'b01, ADDR_SIZE'(wdata_q)};
      end
      SEND_RD: begin
        ram_rx_valid = 1'b1;
        ram_din      = {2'b11, {ADDR_SIZE{1'b0}}};
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    wr_d         = wr_q;
    id_d         = id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp0_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_valid_d = 1'b0;
    rsp1_rdata_d = rsp1_rdata_q;
    rsp_fire     = 1'b0;
    rsp_data     = 8'h00;
`ifdef RAM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          id_d      = grant1;
          rr_last_d = grant1;
          wr_d      = grant1 ? req1_wr    : req0_wr;
          addr_d    = grant1 ? req1_addr  : req0_addr;
          wdata_d   = grant1 ? req1_wdata : req0_wdata;
          state_d   = SEND_ADDR;
        end
      end
      SEND_ADDR:  state_d = wr_q ? SEND_WDATA : SEND_RD;
      SEND_WDATA: state_d = IDLE;
      SEND_RD: begin
        state_d = WAIT_RD;
`ifdef RAM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_RD: begin
        // Real data on the final count takes priority over the timeout.
        if (ram_tx_valid) begin
          rsp_fire = 1'b1;
          rsp_data = ram_dout;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_fire = 1'b1;
          rsp_data = 8'hFF;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (rsp_fire) begin
      state_d = IDLE;
      if (id_q) begin
        rsp1_valid_d = 1'b1;
        rsp1_rdata_d = rsp_data;
      end else begin
        rsp0_valid_d = 1'b1;
        rsp0_rdata_d = rsp_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_last_q    <= 1'b1;
      wr_q         <= 1'b0;
      id_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
      rsp0_valid_q <= 1'b0;
      rsp0_rdata_q <= 8'h00;
      rsp1_valid_q <= 1'b0;
      rsp1_rdata_q <= 8'h00;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      wr_q         <= wr_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_rdata_q <= rsp1_rdata_d;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: per-cycle vector table plus hand-written
// reset, read-wait and (with RAM_ARB_TIMEOUT_EN) watchdog sequences.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_wr = 1'b0;
  logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
  logic       req1_valid = 1'b0, req1_wr = 1'b0;
  logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid, busy;
  logic       ram_tx_valid = 1'b0;
  logic [7:0] ram_dout = 8'h00;
`ifdef RAM_ARB_TIMEOUT_EN
  logic       err_timeout;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout),
    .busy(busy)
`ifdef RAM_ARB_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  typedef struct {
    logic       v0, wr0;
    logic [7:0] a0, d0;
    logic       v1, wr1;
    logic [7:0] a1, d1;
    logic       txv;
    logic [7:0] dout;
    logic       rdy0, rdy1, rxv;
    logic [9:0] din;
    logic       rv0;
    logic [7:0] rd0;
    logic       rv1;
    logic [7:0] rd1;
    logic       bsy;
  } vec_t;

  localparam int NVEC = 23;
  vec_t tbl [NVEC];

  function automatic vec_t mk(
    input logic v0, input logic wr0, input logic [7:0] a0, input logic [7:0] d0,
    input logic v1, input logic wr1, input logic [7:0] a1, input logic [7:0] d1,
    input logic txv, input logic [7:0] dout,
    input logic rdy0, input logic rdy1, input logic rxv, input logic [9:0] din,
    input logic rv0, input logic [7:0] rd0, input logic rv1, input logic [7:0] rd1,
    input logic bsy);
    vec_t v;
    v.v0 = v0; v.wr0 = wr0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.wr1 = wr1; v.a1 = a1; v.d1 = d1;
    v.txv = txv; v.dout = dout;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.rxv = rxv; v.din = din;
    v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1; v.bsy = bsy;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req0_valid = v.v0; req0_wr = v.wr0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_wr = v.wr1; req1_addr = v.a1; req1_wdata = v.d1;
    ram_tx_valid = v.txv; ram_dout = v.dout;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    req0_valid = 1'b0; req0_wr = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_wr = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
    ram_tx_valid = 1'b0; ram_dout = 8'h00;
  endtask

`ifdef RAM_ARB_TIMEOUT_EN
  // Issues a req0 read (accept in cycle 0) and watches cycles 1..25; optionally
  // returns data in cycle 17, the last WAIT_RD cycle before the watchdog fires.
  task automatic runTimeoutRead(input logic inject, input logic [7:0] data,
                                output int err_cycle, output logic rv18, output logic [7:0] rd18);
    err_cycle = 0; rv18 = 1'b0; rd18 = 8'h00;
    @(negedge clk);
    clearInputs();
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 8'h42;
    #1 checkOutput("to.accept", {31'd0, req0_ready}, 32'd1);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      clearInputs();
      if (inject && k == 17) begin
        ram_tx_valid = 1'b1; ram_dout = data;
      end
      #1;
      if (err_timeout && err_cycle == 0) err_cycle = k;
      if (k == 18) begin
        rv18 = rsp0_valid; rd18 = rsp0_rdata;
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int   rsp_seen;
    int   err_cycle;
    logic rv18;
    logic [7:0] rd18;

    //             v0 w0 a0     d0     v1 w1 a1     d1     tx dout   r0 r1 rx din       rv0 rd0   rv1 rd1    bsy
    tbl[0]  = mk(1, 1, 8'h3C, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 10'h000, 0, 8'h00, 0, 8'h00, 0);
    tbl[1]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 10'h03C, 0, 8'h00, 0, 8'h00, 1);
    tbl[2]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 10'h1A5, 0, 8'h00, 0, 8'h00, 1);
    tbl[3]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h3C, 8'h00, 0, 8'h00, 0, 1, 0, 10'h000, 0, 8'h00, 0, 8'h00, 0);
    tbl[4]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 10'h23C, 0, 8'h00, 0, 8'h00, 1);
    tbl[5]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 10'h300, 0, 8'h00, 0, 8'h00, 1);
    tbl[6]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 10'h000, 0, 8'h00, 0, 8'h00, 1);
    tbl[7]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 0, 10'h000, 0, 8'h00, 0, 8'h00, 1);
    tbl[8]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 10'h000, 0, 8'h00, 1, 8'hA5, 0);
    tbl[9]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h77, 0, 0, 0, 10'h000, 0, 8'h00, 0, 8'hA5, 0);
    tbl[10] = mk(1, 1, 8'h10, 8'h11, 1, 1, 8'h20, 8'h22, 1, 8'h66, 1, 0, 0, 10'h000, 0, 8'h00, 0, 8'hA5, 0);
    tbl[11] = mk(1, 1, 8'hFF, 8'hFF, 1, 1, 8'h20, 8'h22, 1, 8'h55, 0, 0, 1, 10'h010, 0, 8'h00, 0, 8'hA5, 1);
    tbl[12] = mk(1, 1, 8'hFF, 8'hFF, 1, 1, 8'h20, 8'h22, 0, 8'h00, 0, 0, 1, 10'h111, 0, 8'h00, 0, 8'hA5, 1);
    tbl[13] = mk(1, 1, 8'hFF, 8'hFF, 1, 1, 8'h20, 8'h22, 0, 8'h00, 0, 1, 0, 10'h000, 0, 8'h00, 0, 8'hA5, 0);
    tbl[14] = mk(1, 1, 8'h30, 8'h33, 1, 1, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, 1, 10'h020, 0, 8'h00, 0, 8'hA5, 1);
    tbl[15] = mk(1, 1, 8'h30, 8'h33, 1, 1, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, 1, 10'h122, 0, 8'h00, 0, 8'hA5, 1);
    tbl[16] = mk(1, 1, 8'h30, 8'h33, 1, 1, 8'hFF, 8'hFF, 0, 8'h00, 1, 0, 0, 10'h000, 0, 8'h00, 0, 8'hA5, 0);
    tbl[17] = mk(1, 1, 8'hFF, 8'hFF, 1, 1, 8'h40, 8'h44, 0, 8'h00, 0, 0, 1, 10'h030, 0, 8'h00, 0, 8'hA5, 1);
    tbl[18] = mk(1, 1, 8'hFF, 8'hFF, 1, 1, 8'h40, 8'h44, 0, 8'h00, 0, 0, 1, 10'h133, 0, 8'h00, 0, 8'hA5, 1);
    tbl[19] = mk(1, 1, 8'hFF, 8'hFF, 1, 1, 8'h40, 8'h44, 0, 8'h00, 0, 1, 0, 10'h000, 0, 8'h00, 0, 8'hA5, 0);
    tbl[20] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 10'h040, 0, 8'h00, 0, 8'hA5, 1);
    tbl[21] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 10'h144, 0, 8'h00, 0, 8'hA5, 1);
    tbl[22] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 10'h000, 0, 8'h00, 0, 8'hA5, 0);

    // Reset values
    #12;
    checkOutput("rst.busy",  {31'd0, busy}, 32'd0);
    checkOutput("rst.rxv",   {31'd0, ram_rx_valid}, 32'd0);
    checkOutput("rst.din",   {22'd0, ram_din}, 32'd0);
    checkOutput("rst.rv0",   {31'd0, rsp0_valid}, 32'd0);
    checkOutput("rst.rv1",   {31'd0, rsp1_valid}, 32'd0);
    checkOutput("rst.rd0",   {24'd0, rsp0_rdata}, 32'd0);
    checkOutput("rst.rd1",   {24'd0, rsp1_rdata}, 32'd0);
`ifdef RAM_ARB_TIMEOUT_EN
    checkOutput("rst.err",   {31'd0, err_timeout}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Per-cycle vector table: write, read, alternating grants, spurious tx_valid
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("v%0d.rdy0", i), {31'd0, req0_ready},   {31'd0, tbl[i].rdy0});
      checkOutput($sformatf("v%0d.rdy1", i), {31'd0, req1_ready},   {31'd0, tbl[i].rdy1});
      checkOutput($sformatf("v%0d.rxv", i),  {31'd0, ram_rx_valid}, {31'd0, tbl[i].rxv});
      checkOutput($sformatf("v%0d.din", i),  {22'd0, ram_din},      {22'd0, tbl[i].din});
      checkOutput($sformatf("v%0d.rv0", i),  {31'd0, rsp0_valid},   {31'd0, tbl[i].rv0});
      checkOutput($sformatf("v%0d.rd0", i),  {24'd0, rsp0_rdata},   {24'd0, tbl[i].rd0});
      checkOutput($sformatf("v%0d.rv1", i),  {31'd0, rsp1_valid},   {31'd0, tbl[i].rv1});
      checkOutput($sformatf("v%0d.rd1", i),  {24'd0, rsp1_rdata},   {24'd0, tbl[i].rd1});
      checkOutput($sformatf("v%0d.busy", i), {31'd0, busy},         {31'd0, tbl[i].bsy});
    end

    // Async reset in the middle of WAIT_RD
    @(negedge clk);
    clearInputs();
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 8'h55;
    #1 checkOutput("ar.accept1", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    clearInputs();
    @(negedge clk);
    @(negedge clk);
    #1 checkOutput("ar.waitbusy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar.busy", {31'd0, busy}, 32'd0);
    checkOutput("ar.rxv",  {31'd0, ram_rx_valid}, 32'd0);
    checkOutput("ar.din",  {22'd0, ram_din}, 32'd0);
    checkOutput("ar.rv1",  {31'd0, rsp1_valid}, 32'd0);
    checkOutput("ar.rd1",  {24'd0, rsp1_rdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ram_tx_valid = 1'b1; ram_dout = 8'h99;
    @(negedge clk);
    ram_tx_valid = 1'b0;
    #1;
    checkOutput("ar.norsp0", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("ar.norsp1", {31'd0, rsp1_valid}, 32'd0);
    checkOutput("ar.idle",   {31'd0, busy}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checkOutput("ar.grant0", {31'd0, req0_ready}, 32'd1);
    checkOutput("ar.grant1", {31'd0, req1_ready}, 32'd0);
    clearInputs();

`ifdef RAM_ARB_TIMEOUT_EN
    // Watchdog: no data, then data on the final count
    runTimeoutRead(1'b0, 8'h00, err_cycle, rv18, rd18);
    checkOutput("to.errcycle", err_cycle, 32'd18);
    checkOutput("to.rv0",      {31'd0, rv18}, 32'd1);
    checkOutput("to.rd0",      {24'd0, rd18}, 32'hFF);
    runTimeoutRead(1'b1, 8'h3C, err_cycle, rv18, rd18);
    checkOutput("to.noerr",    err_cycle, 32'd0);
    checkOutput("to.late.rv0", {31'd0, rv18}, 32'd1);
    checkOutput("to.late.rd0", {24'd0, rd18}, 32'h3C);
`else
    // Without the watchdog a read waits as long as the RAM takes
    @(negedge clk);
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 8'h42;
    #1 checkOutput("wt.accept", {31'd0, req0_ready}, 32'd1);
    rsp_seen = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      clearInputs();
      #1 if (rsp0_valid) rsp_seen++;
    end
    checkOutput("wt.norsp", rsp_seen, 32'd0);
    checkOutput("wt.busy",  {31'd0, busy}, 32'd1);
    @(negedge clk);
    ram_tx_valid = 1'b1; ram_dout = 8'h5A;
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("wt.rv0", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("wt.rd0", {24'd0, rsp0_rdata}, 32'h5A);
    checkOutput("wt.rv1", {31'd0, rsp1_valid}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Two-requester arbiter/sequencer for the shared SPI-slave RAM command port. The RAM port is a 10-bit `din`, `rx_valid`, `tx_valid` and 8-bit `dout`.
- Grants one requester at a time, round-robin, and converts each transaction into the RAM's 2-bit-opcode command words.
- Returns read data to the requester that issued the read.
- Sits between the SPI slave front-end / internal masters and `spi_ram`.

Parameters:
- ADDR_SIZE, 8, RAM address width; `ram_din` width is ADDR_SIZE+2.
- TIMEOUT, 15, maximum cycles spent in WAIT_RD before abort. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 transaction request
- req0_ready  out  1  requester 0 accept; transfer occurs when valid && ready
- req0_wr  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_SIZE  RAM address
- req0_wdata  in  8  write data
- rsp0_valid  out  1  one-cycle read-data strobe to requester 0
- rsp0_rdata  out  8  read data
- req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as above, for requester 1
- ram_din  out  ADDR_SIZE+2  RAM command word; bits [ADDR_SIZE+1:ADDR_SIZE] are the opcode
- ram_rx_valid  out  1  command word valid
- ram_tx_valid  in  1  RAM read data valid
- ram_dout  in  8  RAM read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, rr_last=1, `ram_din`=0, `ram_rx_valid`=0, `rsp*_valid`=0, `rsp*_rdata`=0, `busy`=0, `err_timeout`=0.
  - Asserting reset mid-transaction aborts it; no response is issued.
- Opcodes:
  - 00 = write address
  - 01 = write data
  - 10 = read address
  - 11 = read data (dummy payload 8'h00)
- States: IDLE, SEND_ADDR, SEND_WDATA, SEND_RD, WAIT_RD. All outputs are registered or decoded from registered state.
- IDLE:
  - Grant logic:
    - Only one valid: that requester is granted.
    - Both valid: the requester that is not rr_last is granted.
  - `reqN_ready` = (state==IDLE) && grantN. It is combinational and may depend on the other requester's valid.
  - On transfer:
    - latch wr, addr, wdata and requester id;
    - set rr_last=id;
    - go to SEND_ADDR.
- SEND_ADDR: `ram_rx_valid`=1, `ram_din`={wr?2'b00:2'b10, addr}. Next state: SEND_WDATA if wr, else SEND_RD.
- SEND_WDATA: `ram_rx_valid`=1, `ram_din`={2'b01, wdata}. Next state: IDLE. Writes produce no response.
- SEND_RD: `ram_rx_valid`=1, `ram_din`={2'b11, 8'h00}. Next state: WAIT_RD.
- WAIT_RD:
  - `ram_rx_valid`=0.
  - On `ram_tx_valid`: capture `ram_dout` into `rspN_rdata`, pulse `rspN_valid` for exactly one cycle on the next cycle, go to IDLE.
  - `rspN_rdata` holds until the next read response to that requester.
- `ram_din`=0 whenever `ram_rx_valid`=0.
- Latency, with the accept edge at T:
  - Command words are driven in cycles T+1 and T+2.
  - Write: back in IDLE at T+3. Minimum spacing between accepts is 3 cycles.
  - Read: WAIT_RD from T+3; `rsp_valid` arrives 1 cycle after `ram_tx_valid` is sampled.
- `ram_tx_valid` is ignored in every state except WAIT_RD.
- Requester inputs other than `reqN_valid` are ignored except on the accept edge.
- Round-robin: with both requesters continuously valid, grants alternate 0,1,0,1…; the first grant after reset goes to 0.

Optional Feature:
- Macro: RAM_ARB_TIMEOUT_EN.
- Defined:
  - Adds output `err_timeout` (1 bit, reset 0) and a cycle counter cleared on entry to WAIT_RD.
  - If TIMEOUT cycles elapse in WAIT_RD without `ram_tx_valid`:
    - pulse `err_timeout` for one cycle;
    - pulse `rspN_valid` with `rspN_rdata`=8'hFF;
    - return to IDLE.
  - If `ram_tx_valid` arrives on the same cycle as the final count, the real data wins and `err_timeout` stays 0.
- Undefined: no port, no counter; WAIT_RD waits indefinitely.

Test Plan:
1. Reset, then req0 write addr 0x3C data 0xA5 → req0_ready high 1 cycle; `ram_rx_valid` high 2 cycles with `ram_din`=0x03C then 0x1A5; no rsp; `busy` low again at T+3.
2. req1 read addr 0x3C, RAM model returns 0xA5 → `ram_din`=0x23C then 0x300; `rsp1_valid` high 1 cycle with `rsp1_rdata`=0xA5; `rsp0_valid` stays 0.
3. req0 and req1 both valid from reset, held for 4 writes → grant order 0,1,0,1; each accept is 3 cycles apart.
4. Async reset asserted mid-WAIT_RD → all outputs 0 immediately, state=IDLE; no rsp after reset release; next grant goes to req0.
5. RAM_ARB_TIMEOUT_EN defined, TIMEOUT=15, model never asserts `ram_tx_valid` → `err_timeout` and `rsp0_valid` pulse 15 cycles after WAIT_RD entry, `rsp0_rdata`=0xFF. Repeat with `ram_tx_valid` on cycle 15 → real data returned, no `err_timeout`.
6. Spurious `ram_tx_valid` pulses in IDLE and during SEND_ADDR → no `rsp*_valid`, state sequence unchanged.
